// File: rtl/pmipsl_pkg.sv
// pmipsl_pkg: shared opcodes, ALU and mux encodings, and control states
package pmipsl_pkg;
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd2;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_ANDI  = 4'd7;
    localparam logic [3:0] OP_J     = 4'd8;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_SLT = 4'd4;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PCS_ALU  = 2'd0;
    localparam logic [1:0] PCS_OUT  = 2'd1;
    localparam logic [1:0] PCS_JUMP = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BOFF = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_IEXE   = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op == OP_RTYPE || op == OP_BEQ || op == OP_LW || op == OP_SW ||
               op == OP_ADDI || op == OP_ANDI || op == OP_J;
    endfunction
endpackage

// File: rtl/pmipsl_control_if.sv
// pmipsl_control_if: instruction/status inputs and datapath control outputs
interface pmipsl_control_if #(parameter int CNT_W = 16);
    logic [16:0]      instr;
    logic             zero;
    logic             dmemready;
    logic             pcwrite;
    logic             pcwritecond;
    logic [1:0]       pcsource;
    logic             irwrite;
    logic             regdst;
    logic             regwrite;
    logic             memtoreg;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [2:0]       aluctl;
    logic             dmemread;
    logic             dmemwrite;
    logic             illegal;
    logic [CNT_W-1:0] instret;
    logic [3:0]       probe;

    modport master (
        input  instr, zero, dmemready,
        output pcwrite, pcwritecond, pcsource, irwrite, regdst, regwrite, memtoreg,
               alusrca, alusrcb, aluctl, dmemread, dmemwrite, illegal, instret, probe
    );

    modport slave (
        output instr, zero, dmemready,
        input  pcwrite, pcwritecond, pcsource, irwrite, regdst, regwrite, memtoreg,
               alusrca, alusrcb, aluctl, dmemread, dmemwrite, illegal, instret, probe
    );
endinterface

// File: rtl/pmipsl_alu_decode.sv
// pmipsl_alu_decode: ALU operation select and illegal-funct flag per state
module pmipsl_alu_decode
    import pmipsl_pkg::*;
(
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic [3:0] i_funct,
    output logic [2:0] o_aluctl,
    output logic       o_bad_funct
);
    // functs above SLT have no ALU operation
    assign o_bad_funct = i_funct > FN_SLT;

    // R-type passes funct through in both execute and writeback so ALUOut stays stable
    assign o_aluctl = (i_state == S_RTEXE || i_state == S_RTWB) ? (o_bad_funct ? ALU_ADD : i_funct[2:0]) :
                      (i_state == S_IEXE && i_opcode == OP_ANDI) ? ALU_AND :
                      (i_state == S_BRANCH) ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/pmipsl_control.sv
// pmipsl_control: multicycle PMIPSL sequencer with retire counter and state probe
module pmipsl_control
    import pmipsl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    pmipsl_control_if.master  io_bus
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic [3:0]       w_op;
    logic             w_bad_funct;
    logic             w_retire;

    assign w_op = io_bus.instr[16:13];

    pmipsl_alu_decode u_alu_decode (
        .i_state     (r_state),
        .i_opcode    (w_op),
        .i_funct     (io_bus.instr[3:0]),
        .o_aluctl    (io_bus.aluctl),
        .o_bad_funct (w_bad_funct)
    );

    assign w_retire = r_state == S_MEMWB || r_state == S_RTWB || r_state == S_IWB ||
                      r_state == S_BRANCH || r_state == S_JUMP ||
                      (r_state == S_MEMWR && io_bus.dmemready);

    assign io_bus.illegal = (r_state == S_DECODE && !op_legal(w_op)) ||
                            (r_state == S_RTEXE && w_bad_funct);
    assign io_bus.probe   = r_state;
    assign io_bus.instret = r_instret;

    // state register; reset abandons any instruction in flight
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge i_clock) begin
        if (!i_reset)      r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end

    // next-state: opcode dispatch in decode, memory states wait for dmemready
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = (w_op == OP_RTYPE) ? S_RTEXE :
                               (w_op == OP_BEQ) ? S_BRANCH :
                               (w_op == OP_LW || w_op == OP_SW) ? S_MEMADR :
                               (w_op == OP_ADDI || w_op == OP_ANDI) ? S_IEXE :
                               (w_op == OP_J) ? S_JUMP : S_FETCH;
            S_MEMADR: w_next = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = io_bus.dmemready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = io_bus.dmemready ? S_FETCH : S_MEMWR;
            S_RTEXE:  w_next = w_bad_funct ? S_FETCH : S_RTWB;
            S_IEXE:   w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore datapath controls; every enable defaults off
    always_comb begin
        io_bus.pcwrite     = 1'b0;
        io_bus.pcwritecond = 1'b0;
        io_bus.pcsource    = PCS_ALU;
        io_bus.irwrite     = 1'b0;
        io_bus.regdst      = 1'b0;
        io_bus.regwrite    = 1'b0;
        io_bus.memtoreg    = 1'b0;
        io_bus.alusrca     = 1'b0;
        io_bus.alusrcb     = SRCB_RT;
        io_bus.dmemread    = 1'b0;
        io_bus.dmemwrite   = 1'b0;
        case (r_state)
            S_FETCH: begin
                io_bus.irwrite = 1'b1;
                io_bus.alusrcb = SRCB_ONE;
                io_bus.pcwrite = 1'b1;
            end
            S_DECODE: io_bus.alusrcb = SRCB_BOFF;
            S_MEMADR, S_IEXE: begin
                io_bus.alusrca = 1'b1;
                io_bus.alusrcb = SRCB_IMM;
            end
            S_MEMRD: io_bus.dmemread = 1'b1;
            S_MEMWB: begin
                io_bus.memtoreg = 1'b1;
                io_bus.regwrite = 1'b1;
            end
            S_MEMWR: io_bus.dmemwrite = 1'b1;
            S_RTEXE: io_bus.alusrca = 1'b1;
            S_RTWB: begin
                io_bus.regdst   = 1'b1;
                io_bus.regwrite = 1'b1;
            end
            S_IWB: io_bus.regwrite = 1'b1;
            S_BRANCH: begin
                io_bus.alusrca     = 1'b1;
                io_bus.pcwritecond = 1'b1;
                io_bus.pcsource    = PCS_OUT;
            end
            S_JUMP: begin
                io_bus.pcwrite  = 1'b1;
                io_bus.pcsource = PCS_JUMP;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pmipsl_control.sv
// tb_pmipsl_control: directed instruction sequences checked through an expectation queue
module tb_pmipsl_control;
    typedef struct {
        string       nm;
        logic [3:0]  probe;
        logic [6:0]  en;
        logic [9:0]  mv;
        logic [9:0]  mm;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t q[$];
    int total = 0;
    int bad = 0;

    pmipsl_control_if #(.CNT_W(16)) bus ();

    pmipsl_control #(.CNT_W(16)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .io_bus  (bus.master)
    );

    always #5 clk = ~clk;

    // enables packed as {pcwrite, pcwritecond, irwrite, regwrite, dmemread, dmemwrite, illegal}
    function automatic logic [6:0] en_of(input logic [3:0] st);
        case (st)
            4'd0:              return 7'b1010000;
            4'd3:              return 7'b0000100;
            4'd4, 4'd7, 4'd9:  return 7'b0001000;
            4'd5:              return 7'b0000010;
            4'd10:             return 7'b0100000;
            4'd11:             return 7'b1000000;
            default:           return 7'b0000000;
        endcase
    endfunction

    // {mask, value}; fields {pcsource[1:0], regdst, memtoreg, alusrca, alusrcb[1:0], aluctl[2:0]}
    function automatic logic [19:0] mux_of(input logic [3:0] st, input logic [2:0] alu);
        case (st)
            4'd0:  return {10'b11_0_0_1_11_111, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0};
            4'd1:  return {10'b00_0_0_1_11_111, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0};
            4'd2:  return {10'b00_0_0_1_11_111, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0};
            4'd4:  return {10'b00_1_1_0_00_000, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0};
            4'd6:  return {10'b00_0_0_1_11_111, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, alu};
            4'd7:  return {10'b00_1_1_0_00_111, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, alu};
            4'd8:  return {10'b00_0_0_1_11_111, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, alu};
            4'd9:  return {10'b00_1_1_0_00_000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
            4'd10: return {10'b11_0_0_1_11_111, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1};
            4'd11: return {10'b11_0_0_0_00_000, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
            default: return 20'd0;
        endcase
    endfunction

    // queue the expected outputs for the current cycle, then advance one clock
    task automatic cyc(input string nm, input logic [3:0] st, input logic [2:0] alu,
                       input logic ill, input logic [15:0] cnt);
        exp_t e;
        e.nm    = nm;
        e.probe = st;
        e.cnt   = cnt;
        e.en    = en_of(st) | {6'b0, ill};
        {e.mm, e.mv} = mux_of(st, alu);
        if (ill) e.mm[2:0] = 3'b000;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] en;
            logic [9:0] mx;
            e  = q.pop_front();
            en = {bus.pcwrite, bus.pcwritecond, bus.irwrite, bus.regwrite,
                  bus.dmemread, bus.dmemwrite, bus.illegal};
            mx = {bus.pcsource, bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.aluctl};
            total += 4;
            if (bus.probe !== e.probe) begin
                bad++;
                $display("FAIL %s probe: got %0d want %0d", e.nm, bus.probe, e.probe);
            end
            if (en !== e.en) begin
                bad++;
                $display("FAIL %s enables: got %b want %b", e.nm, en, e.en);
            end
            if ((mx & e.mm) !== (e.mv & e.mm)) begin
                bad++;
                $display("FAIL %s muxes: got %b want %b mask %b", e.nm, mx, e.mv, e.mm);
            end
            if (bus.instret !== e.cnt) begin
                bad++;
                $display("FAIL %s instret: got %0d want %0d", e.nm, bus.instret, e.cnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.instr = {4'd6, 3'd0, 3'd5, 7'd3};
        bus.zero = 1'b0;
        bus.dmemready = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", 4'd0, 3'd0, 1'b0, 16'd0);
        rst_n = 1'b1;
        // addi $5,$0,3
        cyc("addi_f",   4'd0, 3'd0, 1'b0, 16'd0);
        cyc("addi_d",   4'd1, 3'd0, 1'b0, 16'd0);
        cyc("addi_ex",  4'd8, 3'd0, 1'b0, 16'd0);
        cyc("addi_wb",  4'd9, 3'd0, 1'b0, 16'd0);
        // slt $4,$3,$0
        bus.instr = {4'd0, 3'd3, 3'd0, 3'd4, 4'd4};
        cyc("slt_f",    4'd0, 3'd0, 1'b0, 16'd1);
        cyc("slt_d",    4'd1, 3'd0, 1'b0, 16'd1);
        cyc("slt_ex",   4'd6, 3'd4, 1'b0, 16'd1);
        cyc("slt_wb",   4'd7, 3'd4, 1'b0, 16'd1);
        // lw with three wait cycles
        bus.instr = {4'd4, 3'd1, 3'd2, 7'd5};
        cyc("lw_f",     4'd0, 3'd0, 1'b0, 16'd2);
        cyc("lw_d",     4'd1, 3'd0, 1'b0, 16'd2);
        cyc("lw_adr",   4'd2, 3'd0, 1'b0, 16'd2);
        for (int i = 0; i < 3; i++) cyc("lw_wait", 4'd3, 3'd0, 1'b0, 16'd2);
        bus.dmemready = 1'b1;
        cyc("lw_rd",    4'd3, 3'd0, 1'b0, 16'd2);
        bus.dmemready = 1'b0;
        cyc("lw_wb",    4'd4, 3'd0, 1'b0, 16'd2);
        // beq taken
        bus.instr = {4'd2, 3'd1, 3'd2, 7'h7e};
        bus.zero = 1'b1;
        cyc("beq_f",    4'd0, 3'd0, 1'b0, 16'd3);
        cyc("beq_d",    4'd1, 3'd0, 1'b0, 16'd3);
        cyc("beq_br",   4'd10, 3'd1, 1'b0, 16'd3);
        bus.zero = 1'b0;
        // j 20
        bus.instr = {4'd8, 13'd20};
        cyc("j_f",      4'd0, 3'd0, 1'b0, 16'd4);
        cyc("j_d",      4'd1, 3'd0, 1'b0, 16'd4);
        cyc("j_j",      4'd11, 3'd0, 1'b0, 16'd4);
        // andi $3,$2,15
        bus.instr = {4'd7, 3'd2, 3'd3, 7'h0f};
        cyc("andi_f",   4'd0, 3'd0, 1'b0, 16'd5);
        cyc("andi_d",   4'd1, 3'd0, 1'b0, 16'd5);
        cyc("andi_ex",  4'd8, 3'd2, 1'b0, 16'd5);
        cyc("andi_wb",  4'd9, 3'd0, 1'b0, 16'd5);
        // sw with memory ready on entry
        bus.instr = {4'd5, 3'd1, 3'd2, 7'd1};
        bus.dmemready = 1'b1;
        cyc("sw_f",     4'd0, 3'd0, 1'b0, 16'd6);
        cyc("sw_d",     4'd1, 3'd0, 1'b0, 16'd6);
        cyc("sw_adr",   4'd2, 3'd0, 1'b0, 16'd6);
        cyc("sw_wr",    4'd5, 3'd0, 1'b0, 16'd6);
        bus.dmemready = 1'b0;
        // undefined opcode 15
        bus.instr = {4'd15, 13'd0};
        cyc("bad_op_f", 4'd0, 3'd0, 1'b0, 16'd7);
        cyc("bad_op_d", 4'd1, 3'd0, 1'b1, 16'd7);
        // R-type funct 9
        bus.instr = {4'd0, 3'd1, 3'd2, 3'd3, 4'd9};
        cyc("bad_fn_f", 4'd0, 3'd0, 1'b0, 16'd7);
        cyc("bad_fn_d", 4'd1, 3'd0, 1'b0, 16'd7);
        cyc("bad_fn_x", 4'd6, 3'd0, 1'b1, 16'd7);
        // sw stalled, then reset in the middle of the write
        bus.instr = {4'd5, 3'd1, 3'd2, 7'd2};
        cyc("swr_f",    4'd0, 3'd0, 1'b0, 16'd7);
        cyc("swr_d",    4'd1, 3'd0, 1'b0, 16'd7);
        cyc("swr_adr",  4'd2, 3'd0, 1'b0, 16'd7);
        cyc("swr_wr0",  4'd5, 3'd0, 1'b0, 16'd7);
        cyc("swr_wr1",  4'd5, 3'd0, 1'b0, 16'd7);
        rst_n = 1'b0;
        cyc("swr_rst",  4'd5, 3'd0, 1'b0, 16'd7);
        cyc("swr_post", 4'd0, 3'd0, 1'b0, 16'd0);
        rst_n = 1'b1;
        cyc("swr_run",  4'd0, 3'd0, 1'b0, 16'd0);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pmipsl_control.md
Name: pmipsl_control

Overview:
- Multicycle control unit for the PMIPSL 16-bit processor. Sequences fetch, decode, execute, memory and writeback for each 17-bit instruction.
- Drives every datapath mux, ALU, register-file and data-memory enable. Holds in memory states until the DMemory_IO device signals ready.
- Exposes its state on the debug probe and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 at posedge clears state)
- instr  in  17  instruction register contents; opcode [16:13], rs [12:10], rt [9:7], imm7 [6:0]; R-type rd [6:4], funct [3:0]
- zero  in  1  ALU zero flag
- dmemready  in  1  data memory has completed the current read/write
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load when zero==1 (beq)
- pcsource  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target
- irwrite  out  1  latch imemrdata into IR
- regdst  out  1  0=rt, 1=rd
- regwrite  out  1  register file write enable
- memtoreg  out  1  0=ALUOut, 1=MDR
- alusrca  out  1  0=PC, 1=rs
- alusrcb  out  2  0=rt, 1=const 1, 2=sign-ext imm7, 3=sign-ext imm7 (branch offset)
- aluctl  out  3  0=ADD,1=SUB,2=AND,3=OR,4=SLT
- dmemread  out  1  data memory read enable
- dmemwrite  out  1  data memory write enable
- illegal  out  1  one-cycle pulse on undecodable opcode/funct
- instret  out  CNT_W  retired-instruction count
- probe  out  4  current state encoding

Behaviour:
- Reset (reset==0 at posedge): state=FETCH, instret=0, illegal=0. All outputs take the FETCH Moore values below. Reset has priority over any in-progress instruction; a pending write is abandoned.
- Outputs are combinational from state and instr (Moore except aluctl/regdst decode). Default for all enables is 0.
- States and codes:
  - FETCH (0): irwrite=1, alusrca=0, alusrcb=1, aluctl=ADD, pcsource=0, pcwrite=1. Next DECODE.
  - DECODE (1): alusrca=0, alusrcb=3, aluctl=ADD (branch target into ALUOut). Next by opcode: 0 RTYPE→RTEXE; 2 BEQ→BRANCH; 4 LW and 5 SW→MEMADR; 6 ADDI and 7 ANDI→IEXE; 8 J→JUMP. Any other opcode→FETCH with illegal=1.
  - MEMADR (2): alusrca=1, alusrcb=2, ADD. Next LW→MEMRD, SW→MEMWR.
  - MEMRD (3): dmemread=1. Stays while dmemready==0; →MEMWB when ready.
  - MEMWB (4): regdst=0, memtoreg=1, regwrite=1. Retire. →FETCH.
  - MEMWR (5): dmemwrite=1. Stays while dmemready==0; retire on ready. →FETCH.
  - RTEXE (6): alusrca=1, alusrcb=0, aluctl=funct[2:0] for funct 0..4. funct>4: illegal=1, →FETCH, no retire. Otherwise →RTWB.
  - RTWB (7): regdst=1, memtoreg=0, regwrite=1, aluctl held. Retire. →FETCH.
  - IEXE (8): alusrca=1, alusrcb=2, aluctl=ADD (ADDI) or AND (ANDI). →IWB.
  - IWB (9): regdst=0, memtoreg=0, regwrite=1. Retire. →FETCH.
  - BRANCH (10): alusrca=1, alusrcb=0, SUB, pcwritecond=1, pcsource=1. Retire. →FETCH.
  - JUMP (11): pcwrite=1, pcsource=2. Retire. →FETCH.
- Latency in cycles: BEQ/J 3; R-type/ADDI/ANDI 4; SW 4 + wait; LW 5 + wait.
- Destination register 0: regwrite still asserted; the register file ignores writes to $0.
- instret increments by 1 on the retire cycle and wraps at 2^CNT_W-1→0. It is never incremented on an illegal instruction.
- dmemready high in the same cycle the state is entered means no wait states.
- Unused state codes 12..15 return to FETCH.

Decomposition:
- Shared package pmipsl_pkg holds:
  - opcode constants (RTYPE=0, BEQ=2, LW=4, SW=5, ADDI=6, ANDI=7, J=8)
  - funct constants (0..4)
  - aluctl codes
  - pcsource/alusrcb encodings
  - state encodings 0..11
- Natural sub-module: pmipsl_alu_decode, combinational mapping of (state, opcode, funct) to aluctl and the illegal-funct flag.

Test Plan:
- Reset low 2 cycles with instr=addi $5,$0,3 ({6,0,5,7'd3}), then reset high:
  - probe sequence 0,1,8,9,0
  - regwrite=1 only in IWB, regdst=0
  - instret=1 after IWB
- R-type slt ({0,3,0,4,4}): probe 0,1,6,7; aluctl=4 in RTEXE and RTWB; regdst=1 in RTWB.
- lw with dmemready low 3 cycles: probe 0,1,2,3,3,3,3,4; dmemread high for all 4 MEMRD cycles; memtoreg=1 in MEMWB.
- beq with zero=1: probe 0,1,10,0; pcwritecond=1 and pcsource=1 in BRANCH; aluctl=SUB.
- Opcode 15, then R-type funct 9:
  - illegal pulses once each, in DECODE and RTEXE respectively
  - return to FETCH; instret unchanged
- sw with dmemready held low, reset driven low mid-MEMWR: next cycle probe=0, dmemwrite=0, instret=0.
